// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the MEM-stage data memory access controller:
//   - access size encodings (SZ_BYTE, SZ_HALF, SZ_WORD; 2'b11 behaves as word)
//   - controller state encoding
//   - size_mask():     right-aligned byte-enable mask for an access size
//   - is_misaligned(): true when an access crosses a word boundary
// -----------------------------------------------------------------------------
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001;
            SZ_HALF: mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // A half at offset 3 or a word at any non-zero offset spills into the
    // next word; bytes and halves at offsets 0..2 always fit.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = (offset == 2'd3);
            default: mis = (offset != 2'd0);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for one memory beat.
// Ports:
//   size         in  2   access size (mem_access_pkg encoding)
//   offset       in  2   byte offset of the access inside its first word
//   beat         in  1   0 = first beat (base word), 1 = second beat (next word)
//   wdata        in  32  right-aligned store data
//   rdata_lo     in  32  word returned by the first beat
//   rdata_hi     in  32  word returned by the second beat
//   be           out 4   byte enables for the selected beat
//   lane_wdata   out 32  store data shifted onto its byte lanes for the beat
//   merged_rdata out 32  split load re-assembled right-aligned, unused bytes 0
// -----------------------------------------------------------------------------
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        beat,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_lo,
    input  logic [31:0] rdata_hi,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] merged_rdata
);

    logic [3:0]  mask;
    logic [7:0]  be_wide;
    logic [63:0] wdata_wide;
    logic [4:0]  rshift;
    logic [5:0]  lshift;
    logic [31:0] keep;

    assign mask = size_mask(size);

    // Shifting into a double-width vector yields both beats at once: the low
    // half is what lands in the base word, the high half spills to the next.
    assign be_wide    = {4'b0000, mask} << offset;
    assign wdata_wide = {32'h0, wdata} << {offset, 3'b000};

    assign be         = beat ? be_wide[7:4]     : be_wide[3:0];
    assign lane_wdata = beat ? wdata_wide[63:32] : wdata_wide[31:0];

    // Upper bytes of the first word become the low bytes of the result and
    // the low bytes of the second word fill in above them.
    assign rshift = {offset, 3'b000};
    assign lshift = 6'd32 - {1'b0, rshift};
    assign keep   = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};

    assign merged_rdata = ((rdata_lo >> rshift) | (rdata_hi << lshift)) & keep;

endmodule

// File: rtl/data_mem_access.sv
// -----------------------------------------------------------------------------
// data_mem_access
// MEM-stage controller for a variable-latency word-wide data memory. Turns a
// byte-addressed load/store into one (or, for boundary-crossing accesses, two)
// word-addressed beats with byte enables, stalls the pipeline until the memory
// acknowledges, and registers the loaded word and byte offset for the
// write-back data extender.
//
// Build option: define MISALIGN_SPLIT_EN to split boundary-crossing accesses
// into two beats. Without it such requests are rejected (MisalignErr pulse, no
// memory traffic).
//
// Parameter:
//   ACK_TIMEOUT         0 = wait forever; N>0 aborts a beat after N cycles
//                       without MemAck (MisalignErr pulse, no LoadValidW)
// Ports:
//   CPU_CLK, CPU_RST_N  clock, asynchronous active-low reset
//   ReqValid/ReqWrite/ReqSize/ReqAddr/ReqWData   request from MEM stage
//   Stall               freeze pipeline up to and including MEM
//   MemReq/MemWe/MemAddr/MemBe/MemWData          memory beat (0 when idle)
//   MemAck/MemRData     one-cycle acknowledge with read data
//   LoadWordW/LoadedBytesSelectW/LoadValidW      registered load result
//   MisalignErr         one-cycle pulse on rejected or timed-out access
// -----------------------------------------------------------------------------
module data_mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST_N,
    input  logic        ReqValid,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        Stall,
    output logic        MemReq,
    output logic        MemWe,
    output logic [29:0] MemAddr,
    output logic [3:0]  MemBe,
    output logic [31:0] MemWData,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic [31:0] LoadWordW,
    output logic [1:0]  LoadedBytesSelectW,
    output logic        LoadValidW,
    output logic        MisalignErr
);

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    // The timer only ever holds 0..ACK_TIMEOUT-1 before the beat ends.
    localparam int unsigned TIMER_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    state_t state_q, state_d;

    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        beat1_q;
    logic [1:0]         size_q;
    logic               write_q;
    logic               split_q;
    logic [TIMER_W-1:0] timer_q;

    logic        in_beat;
    logic        second_beat;
    logic        req_misaligned;
    logic        timeout_hit;
    logic        accept;
    logic        reject;
    logic        beat1_ack;
    logic        finish_ok;
    logic        abort;
    logic [3:0]  beat_be;
    logic [31:0] beat_wdata;
    logic [31:0] merged_rdata;

    assign in_beat        = (state_q == BEAT1) || (state_q == BEAT2);
    assign second_beat    = (state_q == BEAT2);
    assign req_misaligned = is_misaligned(ReqSize, ReqAddr[1:0]);
    assign timeout_hit    = (ACK_TIMEOUT != 0) &&
                            (32'(timer_q) == ACK_TIMEOUT - 32'd1);

    mem_lane_align u_align (
        .size         (size_q),
        .offset       (addr_q[1:0]),
        .beat         (second_beat),
        .wdata        (wdata_q),
        .rdata_lo     (beat1_q),
        .rdata_hi     (MemRData),
        .be           (beat_be),
        .lane_wdata   (beat_wdata),
        .merged_rdata (merged_rdata)
    );

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        reject    = 1'b0;
        beat1_ack = 1'b0;
        finish_ok = 1'b0;
        abort     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    accept = 1'b1;
                    if (req_misaligned && !SPLIT_EN) begin
                        reject  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = BEAT1;
                    end
                end
            end
            BEAT1: begin
                if (MemAck) begin
                    if (split_q) begin
                        beat1_ack = 1'b1;
                        state_d   = BEAT2;
                    end else begin
                        finish_ok = 1'b1;
                        state_d   = DONE;
                    end
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = DONE;
                end
            end
            BEAT2: begin
                if (MemAck) begin
                    finish_ok = 1'b1;
                    state_d   = DONE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stall is forced low while reset is asserted even if MEM still presents
    // a request, so every output reads 0 during reset.
    assign Stall    = CPU_RST_N && (in_beat || ((state_q == IDLE) && ReqValid));
    assign MemReq   = in_beat;
    assign MemWe    = in_beat && write_q;
    assign MemAddr  = in_beat ? (addr_q[31:2] + {29'd0, second_beat}) : 30'd0;
    assign MemBe    = in_beat ? beat_be : 4'd0;
    assign MemWData = in_beat ? beat_wdata : 32'd0;

    // NOTE: state is updated with non-blocking assignments so all registers
    // sample the same pre-edge values regardless of statement order.
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state_q            <= IDLE;
            addr_q             <= '0;
            wdata_q            <= '0;
            beat1_q            <= '0;
            size_q             <= '0;
            write_q            <= 1'b0;
            split_q            <= 1'b0;
            timer_q            <= '0;
            LoadWordW          <= '0;
            LoadedBytesSelectW <= '0;
            LoadValidW         <= 1'b0;
            MisalignErr        <= 1'b0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                addr_q  <= ReqAddr;
                size_q  <= ReqSize;
                wdata_q <= ReqWData;
                write_q <= ReqWrite;
                split_q <= SPLIT_EN && req_misaligned;
            end

            if (beat1_ack) begin
                beat1_q <= MemRData;
            end

            // Restart the wait count whenever a beat begins or ends.
            if (!in_beat || (state_d != state_q)) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TIMER_W'(1);
            end

            LoadValidW  <= finish_ok && !write_q;
            MisalignErr <= reject || abort;

            if (finish_ok && !write_q) begin
                LoadWordW          <= split_q ? merged_rdata : MemRData;
                LoadedBytesSelectW <= split_q ? 2'b00 : addr_q[1:0];
            end
        end
    end

endmodule

// File: doc/data_mem_access.md
# data_mem_access

Memory-stage access controller between the pipeline's MEM stage and a variable-latency word-wide data memory. It converts a byte-addressed load/store request into word-addressed memory transactions with byte enables, and stalls the pipeline until the memory acknowledges. It registers the returned word and byte offset for the write-back-stage data extender. Accesses that cross a word boundary are optionally split into two memory beats.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 0: 0 disables the timeout; N>0 aborts a beat after N cycles without `MemAck`.

Ports:
- `CPU_CLK` in 1: single clock, all state updates on the rising edge.
- `CPU_RST_N` in 1: asynchronous, active-low reset.
- `ReqValid` in 1: MEM stage holds a load or store; stable until `Stall` is low.
- `ReqWrite` in 1: 1 means store, 0 means load.
- `ReqSize` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `ReqAddr` in 32: byte address.
- `ReqWData` in 32: store data, right-aligned.
- `Stall` out 1: freezes the pipeline up to and including MEM.
- `MemReq` out 1: memory request, held until `MemAck`.
- `MemWe` out 1: write beat.
- `MemAddr` out 30: word address.
- `MemBe` out 4: byte enables.
- `MemWData` out 32: lane-aligned write data.
- `MemAck` in 1: one-cycle acknowledge; read data is valid in the same cycle.
- `MemRData` in 32: read word.
- `LoadWordW` out 32: word passed to the data extender.
- `LoadedBytesSelectW` out 2: byte offset for the data extender.
- `LoadValidW` out 1: one-cycle pulse when a load completes.
- `MisalignErr` out 1: one-cycle pulse when an access is rejected or times out.

## Operation
- States:
  - IDLE: if `ReqValid`, latch addr/size/data/write and go to BEAT1.
  - BEAT1: drive beat 1. On `MemAck`, go to BEAT2 if the access is split, otherwise to DONE.
  - BEAT2: drive beat 2. On `MemAck`, go to DONE.
  - DONE: always returns to IDLE after one cycle.
- Misaligned access: half at offset 3, or word at offset ≠0. Offset o = `ReqAddr[1:0]`.
- Beat 1:
  - `MemAddr` = A[31:2].
  - `MemBe` = (size mask 0001/0011/1111 << o) & 4'hF.
  - `MemWData` = `ReqWData` << 8·o.
- Beat 2 (split only):
  - `MemAddr` = A[31:2]+1, modulo 2^30 (0x3FFFFFFF wraps to 0).
  - `MemBe` = size mask >> (4−o).
  - `MemWData` = `ReqWData` >> 8·(4−o).
- Load, unsplit: `LoadWordW` = raw `MemRData`; `LoadedBytesSelectW` = o.
- Load, split: `LoadWordW` = {beat2 low bytes, beat1 high bytes}, right-aligned, upper bytes zero; `LoadedBytesSelectW` = 00.
- Stores: `LoadValidW` stays 0; `LoadWordW` and `LoadedBytesSelectW` hold their previous values.
- `MemAck` is ignored while `MemReq` is low.
- `MemReq` falls the cycle after `MemAck`; beat 2 starts on that same edge.
- Timeout: with `ACK_TIMEOUT`>0, the counter resets at each beat start. On expiry, drop `MemReq`, go to DONE, pulse `MisalignErr`, and raise no `LoadValidW`.
- Reset, asserted at any time including mid-beat: state IDLE, all outputs 0, `MemReq` low immediately (asynchronous).

## Timing
- `Stall` = (state ∈ {BEAT1, BEAT2}) or (state = IDLE and `ReqValid`). It is combinational, so it is high in the request cycle.
- Zero-wait memory (ack in the first BEAT cycle):
  - Unsplit access: 3 cycles (IDLE, BEAT1, DONE).
  - Split access: 4 cycles.
- Each wait cycle adds one.
- DONE has `Stall` = 0. The pipeline advances at the end of DONE, and the next request is sampled in IDLE on the following cycle.
- `LoadWordW`, `LoadedBytesSelectW` and `LoadValidW` are registered and valid during DONE. `LoadWordW` and `LoadedBytesSelectW` persist until the next load.
- `MemAddr`, `MemBe`, `MemWData` and `MemWe` are stable while `MemReq` is high, and 0 when it is low.

## Configuration
- `MISALIGN_SPLIT_EN` defined: misaligned accesses are split into two beats as above.
- `MISALIGN_SPLIT_EN` undefined: a misaligned request goes IDLE→DONE with no `MemReq` and pulses `MisalignErr`. The access is 2 cycles, no `LoadValidW`, and no memory write.

## Structure
- Shared package `mem_access_pkg`:
  - size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`);
  - state enum (IDLE, BEAT1, BEAT2, DONE);
  - size-mask function.
- One combinational sub-module, `mem_lane_align`: computes `MemBe` and `MemWData` for a beat from (size, offset, beat index, wdata), and merges read beats into the load word.

## Test plan
- LW at 0x100, ack after 2 waits:
  - `MemAddr` = 0x40, `MemBe` = 1111;
  - `Stall` high 4 cycles;
  - `LoadWordW` = `MemRData`, select 00, `LoadValidW` pulses once.
- SB 0xAB at 0x203:
  - `MemBe` = 1000, `MemWData` = 0xAB000000, `MemWe` = 1;
  - `LoadValidW` stays 0.
- LW at 0x102 with split enabled, mem[0x40] = 0x11223344, mem[0x41] = 0x55667788:
  - beat addresses 0x40 then 0x41, BE 1100 then 0011;
  - `LoadWordW` = 0x77881122, select 00.
- Same LW at 0x102 with split disabled:
  - no `MemReq`, `MisalignErr` pulses;
  - 2-cycle stall profile (`Stall` high in IDLE, low in DONE).
- SH 0xBEEF at 0xFFFFFFFF, split enabled:
  - beat 1 at 0x3FFFFFFF, BE 1000, data 0xEF000000;
  - beat 2 at 0x00000000, BE 0001, data 0x000000BE.
- `CPU_RST_N` low during BEAT1 wait:
  - `MemReq` and `Stall` drop immediately;
  - a later `MemAck` produces no `LoadValidW`;
  - after release, a new request is accepted normally.
